// File: rtl/tag_fifo.sv
// Free-tag pool: circular FIFO of ROB tags, pre-filled with 0..DEPTH-1 at reset.
// Dispatch pops the head tag, retire pushes tags back, flush reclaims all outstanding tags.
module tag_fifo #(
  parameter int TAG_W = 5,
  parameter int DEPTH = 1 << TAG_W
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Dispatch_tag_ren,
  output logic [TAG_W-1:0] Tag_out,
  output logic             Tag_empty,
  output logic [TAG_W:0]   Free_count,
  input  logic             Retire_valid,
  input  logic [TAG_W-1:0] Retire_rd_tag,
  input  logic             Flush,
  output logic             Err
);

  localparam logic [TAG_W:0] FULL_COUNT = (TAG_W+1)'(DEPTH);

  logic [TAG_W-1:0] mem [DEPTH];
  logic [TAG_W-1:0] rd_ptr;
  logic [TAG_W-1:0] wr_ptr;
  logic [TAG_W:0]   count;
  logic             err_q;

  logic empty;
  logic full;
  logic do_pop;
  logic do_push;
  logic proto_err;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    empty     = 1'b0;
    full      = 1'b0;
    do_pop    = 1'b0;
    do_push   = 1'b0;
    proto_err = 1'b0;

    empty = (count == '0);
    full  = (count == FULL_COUNT);

    if (!Flush) begin
      do_pop  = Dispatch_tag_ren && !empty;
      // At full a simultaneous pop frees the slot, so the push is still legal.
      do_push = Retire_valid && (!full || Dispatch_tag_ren);
      proto_err = (Dispatch_tag_ren && empty) ||
                  (Retire_valid && full && !Dispatch_tag_ren);
    end
  end

  // NOTE: this array must come out of reset holding 0..DEPTH-1, so unlike typical
  // FIFO storage it is reset register-by-register rather than left uninitialised.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= TAG_W'(i);
      end
    end else if (do_push) begin
      mem[wr_ptr] <= Retire_rd_tag;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= FULL_COUNT;
      err_q  <= 1'b0;
    end else begin
      if (proto_err) begin
        err_q <= 1'b1;
      end

      if (Flush) begin
        // Slots outside the valid region hold exactly the outstanding tags,
        // oldest first starting at wr_ptr.
        rd_ptr <= wr_ptr;
        count  <= FULL_COUNT;
      end else begin
        if (do_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (do_push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        case ({do_push, do_pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
      end
    end
  end

  assign Tag_out    = mem[rd_ptr];
  assign Tag_empty  = empty;
  assign Free_count = count;
  assign Err        = err_q;

endmodule

// File: tb/tb_tag_fifo.sv
// Self-checking bench for tag_fifo: a directed vector table plus hand-written
// sequences for exhaustion, flush recovery, overflow and asynchronous reset.
module tb_tag_fifo;

  localparam int TAG_W = 5;
  localparam int DEPTH = 32;

  logic             Clk = 1'b0;
  logic             Reset = 1'b1;
  logic             Dispatch_tag_ren = 1'b0;
  logic [TAG_W-1:0] Tag_out;
  logic             Tag_empty;
  logic [TAG_W:0]   Free_count;
  logic             Retire_valid = 1'b0;
  logic [TAG_W-1:0] Retire_rd_tag = '0;
  logic             Flush = 1'b0;
  logic             Err;

  int n_checks = 0;
  int n_fail   = 0;

  tag_fifo #(.TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
    .Clk              (Clk),
    .Reset            (Reset),
    .Dispatch_tag_ren (Dispatch_tag_ren),
    .Tag_out          (Tag_out),
    .Tag_empty        (Tag_empty),
    .Free_count       (Free_count),
    .Retire_valid     (Retire_valid),
    .Retire_rd_tag    (Retire_rd_tag),
    .Flush            (Flush),
    .Err              (Err)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic             ren;
    logic             rv;
    logic [TAG_W-1:0] rtag;
    logic             flush;
    logic [TAG_W-1:0] exp_tag;
    logic             exp_empty;
    logic [TAG_W:0]   exp_cnt;
    logic             exp_err;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_state(input string name, input int tag, input int empty,
                             input int cnt, input int err);
    check({name, " Tag_out"},    int'(Tag_out),    tag);
    check({name, " Tag_empty"},  int'(Tag_empty),  empty);
    check({name, " Free_count"}, int'(Free_count), cnt);
    check({name, " Err"},        int'(Err),        err);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
  task automatic drive(input logic ren, input logic rv, input logic [TAG_W-1:0] tag,
                       input logic fl);
    @(negedge Clk);
    Dispatch_tag_ren = ren;
    Retire_valid     = rv;
    Retire_rd_tag    = tag;
    Flush            = fl;
  endtask

  task automatic edge_sample();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_inputs();
    Dispatch_tag_ren = 1'b0;
    Retire_valid     = 1'b0;
    Retire_rd_tag    = '0;
    Flush            = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge Clk);
    idle_inputs();
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Pops n tags, checking the show-ahead head before each edge.
  task automatic pop_seq(input string name, input int first, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 1'b0, '0, 1'b0);
      check(name, int'(Tag_out), (first + i) % DEPTH);
      edge_sample();
    end
    drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    // ren rv rtag flush | tag empty cnt err
    vecs[0] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd1, 1'b0, 6'd31, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd2, 1'b0, 6'd30, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd3, 1'b0, 6'd29, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd4, 1'b0, 6'd28, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd5, 1'b0, 6'd27, 1'b0};
    vecs[5] = '{1'b1, 1'b1, 5'd0, 1'b0, 5'd6, 1'b0, 6'd27, 1'b0};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 1'b0, 5'd6, 1'b0, 6'd27, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 5'd1, 1'b0, 5'd6, 1'b0, 6'd28, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 5'd0, 1'b0, 5'd7, 1'b0, 6'd27, 1'b0};

    // Reset state and idle
    #2;
    apply_reset();
    edge_sample();
    check_state("reset_idle", 0, 0, 32, 0);

    // Table: pops, pop+push at mid occupancy, idle, push
    for (int i = 0; i < 9; i++) begin
      drive(vecs[i].ren, vecs[i].rv, vecs[i].rtag, vecs[i].flush);
      edge_sample();
      check_state($sformatf("vec%0d", i), int'(vecs[i].exp_tag), int'(vecs[i].exp_empty),
                  int'(vecs[i].exp_cnt), int'(vecs[i].exp_err));
    end

    // Exhaustion, underflow, then push into empty with no bypass
    apply_reset();
    pop_seq("drain_head", 0, 32);
    edge_sample();
    check_state("drained", 0, 1, 0, 0);
    drive(1'b1, 1'b0, '0, 1'b0);
    edge_sample();
    check_state("underflow", 0, 1, 0, 1);
    drive(1'b0, 1'b1, 5'd7, 1'b0);
    check("push_empty_no_bypass", int'(Tag_empty), 1);
    edge_sample();
    check_state("push7", 7, 0, 1, 1);

    // Flush with simultaneous push and pop
    apply_reset();
    pop_seq("pre_flush_head", 0, 10);
    drive(1'b0, 1'b1, 5'd0, 1'b0);
    edge_sample();
    drive(1'b0, 1'b1, 5'd1, 1'b0);
    edge_sample();
    check_state("pre_flush", 10, 0, 24, 0);
    drive(1'b1, 1'b1, 5'd2, 1'b1);
    edge_sample();
    check_state("flush", 2, 0, 32, 0);
    begin
      logic [DEPTH-1:0] seen;
      int dups;
      seen = '0;
      dups = 0;
      for (int i = 0; i < DEPTH; i++) begin
        drive(1'b1, 1'b0, '0, 1'b0);
        check("post_flush_head", int'(Tag_out), (2 + i) % DEPTH);
        if (seen[Tag_out]) dups++;
        seen[Tag_out] = 1'b1;
        edge_sample();
      end
      check("post_flush_dups", dups, 0);
      check("post_flush_all_seen", int'(&seen), 1);
    end
    drive(1'b0, 1'b0, '0, 1'b0);
    edge_sample();
    check_state("post_flush_drained", 2, 1, 0, 0);
    // Push and pop together at empty: only the push lands, pop flags underflow
    drive(1'b1, 1'b1, 5'd5, 1'b0);
    edge_sample();
    check_state("empty_push_pop", 5, 0, 1, 1);

    // Overflow at full, then asynchronous mid-stream reset
    apply_reset();
    drive(1'b0, 1'b1, 5'd9, 1'b0);
    edge_sample();
    check_state("overflow", 0, 0, 32, 1);
    pop_seq("mem_intact", 0, 32);
    // Push with pop at full: both happen, count stays full
    apply_reset();
    drive(1'b1, 1'b1, 5'd0, 1'b0);
    edge_sample();
    check_state("full_push_pop", 1, 0, 32, 0);
    drive(1'b1, 1'b0, '0, 1'b0);
    edge_sample();
    drive(1'b0, 1'b1, 5'd3, 1'b0);
    edge_sample();
    drive(1'b0, 1'b1, 5'd4, 1'b0);
    edge_sample();
    check_state("pre_async_reset", 2, 0, 32, 1);
    drive(1'b1, 1'b1, 5'd6, 1'b0);
    @(posedge Clk);
    #2;
    Reset = 1'b1;
    #1;
    check_state("async_reset", 0, 0, 32, 0);
    @(negedge Clk);
    idle_inputs();
    Reset = 1'b0;
    edge_sample();
    check_state("after_reset", 0, 0, 32, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tag_fifo.md
# tag_fifo

Free-tag pool for the out-of-order core. Hands a 5-bit tag to every dispatched instruction and takes tags back as the ROB retires them in program order. On a mispredicted taken branch it reclaims every outstanding tag in one cycle. It sits between dispatch (consumer of `Dispatch_Rd_tag`) and the ROB retire port (producer of `Retire_rd_tag`).

## Interface

- `TAG_W`, 5: tag width. `DEPTH` = 2^`TAG_W`.
- `DEPTH`, 32: number of tags and FIFO slots. Must equal 2^`TAG_W`.
- `Clk`, in, 1: clock. All state changes on the rising edge.
- `Reset`, in, 1: asynchronous, active-high reset.
- `Dispatch_tag_ren`, in, 1: dispatch consumes the head tag this cycle.
- `Tag_out`, out, `TAG_W`: head free tag (show-ahead). Meaningful only when `Tag_empty`=0.
- `Tag_empty`, out, 1: no free tag; dispatch must stall.
- `Free_count`, out, `TAG_W`+1: number of free tags, 0..32.
- `Retire_valid`, in, 1: ROB is retiring an instruction; its tag returns to the pool.
- `Retire_rd_tag`, in, `TAG_W`: tag being returned.
- `Flush`, in, 1: mispredict recovery (`Retire_branch` & `Retire_branch_taken`, formed at top level). Reclaims all outstanding tags.
- `Err`, out, 1: sticky protocol-error flag (underflow or overflow).

## Operation

- Storage: `DEPTH` x `TAG_W` register array `mem`; 5-bit `rd_ptr`, 5-bit `wr_ptr` (natural wrap at 31→0); 6-bit `count`.
- Reset (async): `mem[i]`=i for i=0..31, `rd_ptr`=0, `wr_ptr`=0, `count`=32, `Err`=0. Outputs after reset: `Tag_out`=0, `Tag_empty`=0, `Free_count`=32, `Err`=0.
- Combinational outputs: `Tag_out` = `mem[rd_ptr]`, `Tag_empty` = (`count`==0), `Free_count` = `count`.
- Pop: `Dispatch_tag_ren` & `count`!=0 → `rd_ptr`+1, `count`−1.
- Push: `Retire_valid` & `count`!=32 → `mem[wr_ptr]`=`Retire_rd_tag`, `wr_ptr`+1, `count`+1.
- Push and pop in the same cycle:
  - Both legal → both happen; `count` unchanged.
  - With `count`==0, only the push happens. There is no bypass; the returned tag becomes visible on `Tag_out` the next cycle.
  - With `count`==32, both happen and `count` stays 32. The pop frees the slot, so the push is legal.
- Underflow: `Dispatch_tag_ren` with `count`==0 → pop ignored, `Err`←1.
- Overflow: `Retire_valid` with `count`==32 and no simultaneous pop → push ignored, `Err`←1.
- `Err` stays set until `Reset`.
- Flush (highest priority):
  - `rd_ptr`←`wr_ptr`, `count`←32. `mem` and `wr_ptr` are unchanged.
  - Any simultaneous push or pop is dropped and does not set `Err`.
  - Why this is correct: tags are issued and retired in the same program order, so the slots outside the valid region hold exactly the outstanding tags. After flush the oldest outstanding tag is at the head.
- Invariant: the multiset of tags in valid slots plus outstanding tags is always {0..31}. No tag is ever duplicated.

## Timing

- Pop: `Tag_out` presents the tag in the same cycle. The consumed tag is removed at the edge, and the next tag appears after that edge.
- Push: written at the edge. It is visible on `Tag_out` next cycle only if it becomes the head.
- Flush: one cycle. The cycle after flush shows `Free_count`=32, `Tag_empty`=0, `Tag_out`=`mem[wr_ptr]`.
- Reset mid-operation: asynchronous return to the reset state regardless of in-flight pops, pushes or flush.
- No multicycle paths. `Tag_out` is a 32:1 mux of registers.

## Test plan

- Reset, then idle → `Tag_out`=0, `Free_count`=32, `Tag_empty`=0, `Err`=0.
- Three consecutive pops → tags 0,1,2 presented; then `Tag_out`=3, `Free_count`=29.
- 32 pops, then one more pop → `Tag_empty`=1, `Free_count`=0, `Err`=1, pointers unchanged. Then push tag 7 → the next cycle shows `Tag_empty`=0, `Tag_out`=7.
- After a fresh reset, pop tags 0..4, then push tag 0 with a simultaneous pop → tag 5 is consumed, `Free_count` stays 27, `Tag_out`=6.
- After a fresh reset, pop 0..9, push 0 and 1, then assert `Flush` together with push 2 and a pop → `Free_count`=32, `Tag_out`=2, `Err`=0. Popping 32 times yields 2..9, 10..31, 0, 1 with no duplicates.
- At `count`=32, push with no pop → `Err`=1, `Free_count`=32, `mem` unchanged. Assert `Reset` mid-stream → `Err`=0 and the reset state is restored immediately, without waiting for a clock edge.
